// File: rtl/serial_add_controller_if.sv
// Handshake and operand/result bus of the bit-serial add/subtract controller.
// The master side issues start/sub/a/b; the slave side returns the registered
// result, busy/done status and NZCV flags.
interface serial_add_controller_if #(
    parameter int unsigned WIDTH = 64
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output start, sub, a, b,
        input  result, busy, done, flag_n, flag_z, flag_c, flag_v
    );

    modport slave (
        input  start, sub, a, b,
        output result, busy, done, flag_n, flag_z, flag_c, flag_v
    );
endinterface

// File: rtl/serial_add_controller.sv
// Bit-serial add/subtract controller: one full-adder slice is reused for WIDTH
// cycles, LSB first, to build a WIDTH-bit sum/difference plus NZCV flags.
// Optional feature macro: SERIAL_ADD_SUB_EN enables subtraction (a + ~b + 1);
// when undefined the sub input is ignored and only addition is performed.
module serial_add_controller #(
    parameter int unsigned WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_add_controller_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] shreg;
    logic             sub_q;
    logic             carry_q;
    logic [CNT_W-1:0] count;
    logic             zero_acc;

    logic             sub_load;
    logic             b_bit;
    logic             sum;
    logic             cout;

`ifdef SERIAL_ADD_SUB_EN
    // Subtract mode is taken from the request.
    always_comb begin
        sub_load = bus.sub;
    end
`else
    logic unused_sub;
    assign unused_sub = bus.sub;

    // Addition only; subtract request is ignored.
    always_comb begin
        sub_load = 1'b0;
    end
`endif

    // Shared full-adder slice working on the current LSBs.
    always_comb begin
        b_bit = sb[0] ^ sub_q;
        sum   = sa[0] ^ b_bit ^ carry_q;
        cout  = (sa[0] & b_bit) | (carry_q & (sa[0] ^ b_bit));
    end

    // Controller FSM, operand/result shifting and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            sa          <= '0;
            sb          <= '0;
            shreg       <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            count       <= '0;
            zero_acc    <= 1'b0;
            bus.result  <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.flag_n  <= 1'b0;
            bus.flag_z  <= 1'b0;
            bus.flag_c  <= 1'b0;
            bus.flag_v  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    bus.busy <= 1'b0;
                    if (bus.start) begin
                        // The initial carry supplies the +1 of two's-complement subtract.
                        sa       <= bus.a;
                        sb       <= bus.b;
                        sub_q    <= sub_load;
                        carry_q  <= sub_load;
                        count    <= '0;
                        zero_acc <= 1'b1;
                        shreg    <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    sa       <= sa >> 1;
                    sb       <= sb >> 1;
                    shreg    <= {sum, shreg[WIDTH-1:1]};
                    carry_q  <= cout;
                    zero_acc <= zero_acc & ~sum;
                    if (count == LAST_BIT) begin
                        // Final bit: publish result and flags together with done.
                        bus.result <= {sum, shreg[WIDTH-1:1]};
                        bus.flag_n <= sum;
                        bus.flag_z <= zero_acc & ~sum;
                        bus.flag_c <= cout;
                        bus.flag_v <= carry_q ^ cout;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else begin
                        count      <= count + CNT_W'(1);
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_controller.sv
// Directed self-checking bench for serial_add_controller (WIDTH=8 and WIDTH=64).
module tb_serial_add_controller;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    serial_add_controller_if #(.WIDTH(8))  bus8  ();
    serial_add_controller_if #(.WIDTH(64)) bus64 ();

    serial_add_controller #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    serial_add_controller #(.WIDTH(64)) dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one 8-bit request; edges counts the start edge as 1, -1 on timeout.
    task automatic op8(input logic s, input logic [7:0] x, input logic [7:0] y,
                       output int edges);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.sub   = s;
        bus8.a     = x;
        bus8.b     = y;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        edges = 1;
        while (bus8.done !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (bus8.done !== 1'b1) edges = -1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus8.result !== 8'h00) begin
            n_fail++; $display("FAIL reset_result: got %h expected 00", bus8.result);
        end
        n_checks++;
        if ({bus8.busy, bus8.done} !== 2'b00) begin
            n_fail++; $display("FAIL reset_busy_done: got %b expected 00", {bus8.busy, bus8.done});
        end
        n_checks++;
        if ({bus8.flag_n, bus8.flag_z, bus8.flag_c, bus8.flag_v} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000",
                               {bus8.flag_n, bus8.flag_z, bus8.flag_c, bus8.flag_v});
        end
        n_checks++;
        if ({bus64.result, bus64.busy, bus64.done} !== 66'd0) begin
            n_fail++; $display("FAIL reset_w64: got %h expected 0", {bus64.result, bus64.busy, bus64.done});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic_add();
        int e;
        op8(1'b0, 8'h7F, 8'h01, e);
        n_checks++;
        if (e != 9) begin
            n_fail++; $display("FAIL add_latency: got %0d edges expected 9", e);
        end
        n_checks++;
        if (bus8.result !== 8'h80) begin
            n_fail++; $display("FAIL add_result: got %h expected 80", bus8.result);
        end
        n_checks++;
        if ({bus8.flag_n, bus8.flag_z, bus8.flag_c, bus8.flag_v} !== 4'b1001) begin
            n_fail++; $display("FAIL add_flags: got %b expected 1001",
                               {bus8.flag_n, bus8.flag_z, bus8.flag_c, bus8.flag_v});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus8.done !== 1'b0 || bus8.result !== 8'h80) begin
            n_fail++; $display("FAIL add_done_pulse: got done=%b result=%h expected done=0 result=80",
                               bus8.done, bus8.result);
        end
    endtask

    task automatic test_wrap_zero();
        int e;
        op8(1'b0, 8'hFF, 8'h01, e);
        n_checks++;
        if (e != 9 || bus8.result !== 8'h00) begin
            n_fail++; $display("FAIL wrap_result: got %h after %0d edges expected 00 after 9", bus8.result, e);
        end
        n_checks++;
        if ({bus8.flag_n, bus8.flag_z, bus8.flag_c, bus8.flag_v} !== 4'b0110) begin
            n_fail++; $display("FAIL wrap_flags: got %b expected 0110",
                               {bus8.flag_n, bus8.flag_z, bus8.flag_c, bus8.flag_v});
        end
    endtask

    task automatic test_sub();
        int e;
        logic [7:0] r1, r2;
        logic [3:0] f1, f2;
`ifdef SERIAL_ADD_SUB_EN
        r1 = 8'hFE; f1 = 4'b1000;
        r2 = 8'h7F; f2 = 4'b0011;
`else
        r1 = 8'h0C; f1 = 4'b0000;
        r2 = 8'h81; f2 = 4'b1000;
`endif
        op8(1'b1, 8'h05, 8'h07, e);
        n_checks++;
        if (e != 9 || bus8.result !== r1) begin
            n_fail++; $display("FAIL sub1_result: got %h after %0d edges expected %h after 9", bus8.result, e, r1);
        end
        n_checks++;
        if ({bus8.flag_n, bus8.flag_z, bus8.flag_c, bus8.flag_v} !== f1) begin
            n_fail++; $display("FAIL sub1_flags: got %b expected %b",
                               {bus8.flag_n, bus8.flag_z, bus8.flag_c, bus8.flag_v}, f1);
        end
        op8(1'b1, 8'h80, 8'h01, e);
        n_checks++;
        if (e != 9 || bus8.result !== r2) begin
            n_fail++; $display("FAIL sub2_result: got %h after %0d edges expected %h after 9", bus8.result, e, r2);
        end
        n_checks++;
        if ({bus8.flag_n, bus8.flag_z, bus8.flag_c, bus8.flag_v} !== f2) begin
            n_fail++; $display("FAIL sub2_flags: got %b expected %b",
                               {bus8.flag_n, bus8.flag_z, bus8.flag_c, bus8.flag_v}, f2);
        end
    endtask

    task automatic test_ignore_start();
        int e;
        @(negedge clk);
        bus8.start = 1'b1; bus8.sub = 1'b0; bus8.a = 8'h12; bus8.b = 8'h34;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        e = 1;
        repeat (2) begin
            @(posedge clk); #1; e++;
        end
        n_checks++;
        if (bus8.busy !== 1'b1) begin
            n_fail++; $display("FAIL ign_busy: got %b expected 1", bus8.busy);
        end
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55;
        @(posedge clk);
        #1;
        e++;
        bus8.start = 1'b0;
        while (bus8.done !== 1'b1 && e < 40) begin
            @(posedge clk); #1; e++;
        end
        n_checks++;
        if (e != 9 || bus8.result !== 8'h46) begin
            n_fail++; $display("FAIL ign_result: got %h after %0d edges expected 46 after 9", bus8.result, e);
        end
        n_checks++;
        if ({bus8.flag_n, bus8.flag_z, bus8.flag_c, bus8.flag_v} !== 4'b0000) begin
            n_fail++; $display("FAIL ign_flags: got %b expected 0000",
                               {bus8.flag_n, bus8.flag_z, bus8.flag_c, bus8.flag_v});
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        int e;
        @(negedge clk);
        bus8.start = 1'b1; bus8.sub = 1'b0; bus8.a = 8'h10; bus8.b = 8'h20;
        @(posedge clk);
        #1;
        e = 1;
        while (bus8.done !== 1'b1 && e < 40) begin
            @(posedge clk); #1; e++;
        end
        n_checks++;
        if (e != 9 || bus8.result !== 8'h30) begin
            n_fail++; $display("FAIL b2b_first: got %h after %0d edges expected 30 after 9", bus8.result, e);
        end
        bus8.a = 8'hC0; bus8.b = 8'h50;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        n_checks++;
        if ({bus8.busy, bus8.done} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_no_idle: got busy,done=%b expected 10", {bus8.busy, bus8.done});
        end
        e = 1;
        while (bus8.done !== 1'b1 && e < 40) begin
            @(posedge clk); #1; e++;
        end
        n_checks++;
        if (e != 9 || bus8.result !== 8'h10) begin
            n_fail++; $display("FAIL b2b_second: got %h after %0d edges expected 10 after 9", bus8.result, e);
        end
        n_checks++;
        if ({bus8.flag_n, bus8.flag_z, bus8.flag_c, bus8.flag_v} !== 4'b0010) begin
            n_fail++; $display("FAIL b2b_flags: got %b expected 0010",
                               {bus8.flag_n, bus8.flag_z, bus8.flag_c, bus8.flag_v});
        end
    endtask

    task automatic test_abort();
        int seen;
        @(negedge clk);
        bus8.start = 1'b1; bus8.sub = 1'b0; bus8.a = 8'h01; bus8.b = 8'h01;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus8.busy, bus8.done} !== 2'b00 || bus8.result !== 8'h00) begin
            n_fail++; $display("FAIL abort_state: got busy,done=%b result=%h expected 00 and 00",
                               {bus8.busy, bus8.done}, bus8.result);
        end
        n_checks++;
        if ({bus8.flag_n, bus8.flag_z, bus8.flag_c, bus8.flag_v} !== 4'b0000) begin
            n_fail++; $display("FAIL abort_flags: got %b expected 0000",
                               {bus8.flag_n, bus8.flag_z, bus8.flag_c, bus8.flag_v});
        end
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen);
        end
    endtask

    task automatic test_width64();
        int e;
        @(negedge clk);
        bus64.start = 1'b1; bus64.sub = 1'b0;
        bus64.a = 64'hFFFF_FFFF_FFFF_FFFF; bus64.b = 64'd1;
        @(posedge clk);
        #1;
        bus64.start = 1'b0;
        e = 1;
        while (bus64.done !== 1'b1 && e < 200) begin
            @(posedge clk); #1; e++;
        end
        n_checks++;
        if (e != 65) begin
            n_fail++; $display("FAIL w64_latency: got %0d edges expected 65", e);
        end
        n_checks++;
        if (bus64.result !== 64'd0) begin
            n_fail++; $display("FAIL w64_result: got %h expected 0", bus64.result);
        end
        n_checks++;
        if ({bus64.flag_n, bus64.flag_z, bus64.flag_c, bus64.flag_v} !== 4'b0110) begin
            n_fail++; $display("FAIL w64_flags: got %b expected 0110",
                               {bus64.flag_n, bus64.flag_z, bus64.flag_c, bus64.flag_v});
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus8.start  = 1'b0; bus8.sub  = 1'b0; bus8.a  = '0; bus8.b  = '0;
        bus64.start = 1'b0; bus64.sub = 1'b0; bus64.a = '0; bus64.b = '0;
        test_reset();
        test_basic_add();
        test_wrap_zero();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_width64();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
